// File: rtl/axi_ram_slave_if.sv
// AXI3 channel bundle between an interconnect slave port and axi_ram_slave.
// Clock and reset stay outside the bundle as plain ports.
interface axi_ram_slave_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 2
);
    logic [ID_W-1:0]     S_AXI_AWID;
    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic [3:0]          S_AXI_AWLEN;
    logic [2:0]          S_AXI_AWSIZE;
    logic [1:0]          S_AXI_AWBURST;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;
    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WLAST;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;
    logic [ID_W-1:0]     S_AXI_BID;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;
    logic [ID_W-1:0]     S_AXI_ARID;
    logic [ADDR_W-1:0]   S_AXI_ARADDR;
    logic [3:0]          S_AXI_ARLEN;
    logic [2:0]          S_AXI_ARSIZE;
    logic [1:0]          S_AXI_ARBURST;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;
    logic [ID_W-1:0]     S_AXI_RID;
    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RLAST;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface

// File: rtl/axi_ram_slave.sv
// AXI3 RAM slave: independent read/write burst FSMs over a 1W/1R word array.
// Define AXI_RAM_WRAP_EN to support WRAP bursts; otherwise WRAP answers SLVERR.
module axi_ram_slave #(
  parameter int    DATA_W      = 32,
  parameter int    ADDR_W      = 32,
  parameter int    ID_W        = 2,
  parameter int    DEPTH_WORDS = 1024,
  parameter string INIT_FILE   = ""
) (
  input logic            S_AXI_ACLK,
  input logic            S_AXI_ARESETN,
  axi_ram_slave_if.slave s_axi
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  typedef struct packed {
    logic              err;
    logic [ADDR_W-1:0] next;
  } step_t;

  // Error status of the beat at address a, plus the address of the following beat.
  function automatic step_t beat_step(
    input logic [ADDR_W-1:0] a,
    input logic [2:0]        size,
    input logic [1:0]        burst
`ifdef AXI_RAM_WRAP_EN
    , input logic [3:0]      len
`endif
  );
    step_t s;
    logic [ADDR_W-1:0] sz;
`ifdef AXI_RAM_WRAP_EN
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] lo;
`endif
    sz     = ADDR_W'(1) << size;
    s.next = (burst == 2'b00) ? a : a + sz;
    s.err  = ((a >> OFF_W) >= ADDR_W'(DEPTH_WORDS)) || (size > 3'(OFF_W)) || (burst == 2'b11);
`ifdef AXI_RAM_WRAP_EN
    if (burst == 2'b10) begin
      span = sz * (ADDR_W'(len) + ADDR_W'(1));
      lo   = a & ~(span - ADDR_W'(1));
      if (s.next == lo + span) s.next = lo;
      if (!(len inside {4'd1, 4'd3, 4'd7, 4'd15}) || ((a & (sz - ADDR_W'(1))) != '0)) s.err = 1'b1;
    end
`else
    if (burst == 2'b10) s.err = 1'b1;
`endif
    return s;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  w_state_t          w_state, w_next;
  logic [ADDR_W-1:0] w_addr;
  logic [3:0]        w_len, w_cnt;
  logic [2:0]        w_size;
  logic [1:0]        w_burst;
  logic              w_err, w_fire, w_last_beat, w_err_now;
  logic [ID_W-1:0]   b_id;
  logic [1:0]        b_resp;
  step_t             w_st;

  r_state_t          r_state, r_next;
  logic [ADDR_W-1:0] r_addr, rd_a;
  logic [3:0]        r_len, r_cnt;
  logic [2:0]        r_size, rd_size;
  logic [1:0]        r_burst, rd_burst;
  logic              r_last, r_fire_ar, r_fire_r;
  logic [ID_W-1:0]   r_id;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  step_t             r_st;

  // r_addr holds the address of the beat to be fetched next, so one step evaluation
  // serves both the first beat (from AR) and every following beat.
  assign rd_a     = (r_state == R_IDLE) ? s_axi.S_AXI_ARADDR  : r_addr;
  assign rd_size  = (r_state == R_IDLE) ? s_axi.S_AXI_ARSIZE  : r_size;
  assign rd_burst = (r_state == R_IDLE) ? s_axi.S_AXI_ARBURST : r_burst;
`ifdef AXI_RAM_WRAP_EN
  assign w_st = beat_step(w_addr, w_size, w_burst, w_len);
  assign r_st = beat_step(rd_a, rd_size, rd_burst, (r_state == R_IDLE) ? s_axi.S_AXI_ARLEN : r_len);
`else
  assign w_st = beat_step(w_addr, w_size, w_burst);
  assign r_st = beat_step(rd_a, rd_size, rd_burst);
`endif

  assign w_fire      = S_AXI_ARESETN && (w_state == W_DATA) && s_axi.S_AXI_WVALID;
  assign w_last_beat = (w_cnt == w_len);
  assign w_err_now   = w_err | w_st.err | (s_axi.S_AXI_WLAST != w_last_beat);
  assign r_fire_ar   = (r_state == R_IDLE) && s_axi.S_AXI_ARVALID;
  assign r_fire_r    = (r_state == R_DATA) && s_axi.S_AXI_RREADY && !r_last;

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next              = w_state;
    r_next              = r_state;
    s_axi.S_AXI_AWREADY = 1'b0;
    s_axi.S_AXI_WREADY  = 1'b0;
    s_axi.S_AXI_BVALID  = 1'b0;
    s_axi.S_AXI_ARREADY = 1'b0;
    s_axi.S_AXI_RVALID  = 1'b0;
    case (w_state)
      W_IDLE: begin
        s_axi.S_AXI_AWREADY = 1'b1;
        if (s_axi.S_AXI_AWVALID) w_next = W_DATA;
      end
      W_DATA: begin
        s_axi.S_AXI_WREADY = 1'b1;
        if (s_axi.S_AXI_WVALID && w_last_beat) w_next = W_RESP;
      end
      W_RESP: begin
        s_axi.S_AXI_BVALID = 1'b1;
        if (s_axi.S_AXI_BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
    case (r_state)
      R_IDLE: begin
        s_axi.S_AXI_ARREADY = 1'b1;
        if (s_axi.S_AXI_ARVALID) r_next = R_DATA;
      end
      R_DATA: begin
        s_axi.S_AXI_RVALID = 1'b1;
        if (s_axi.S_AXI_RREADY && r_last) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
      b_id    <= '0;
      b_resp  <= RESP_OKAY;
    end else if ((w_state == W_IDLE) && s_axi.S_AXI_AWVALID) begin
      w_addr  <= s_axi.S_AXI_AWADDR;
      w_len   <= s_axi.S_AXI_AWLEN;
      w_size  <= s_axi.S_AXI_AWSIZE;
      w_burst <= s_axi.S_AXI_AWBURST;
      w_cnt   <= '0;
      w_err   <= 1'b0;
      b_id    <= s_axi.S_AXI_AWID;
    end else if (w_fire) begin
      w_addr <= w_st.next;
      w_cnt  <= w_cnt + 4'd1;
      w_err  <= w_err_now;
      if (w_last_beat) b_resp <= w_err_now ? RESP_SLVERR : RESP_OKAY;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (w_fire && !w_st.err) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (s_axi.S_AXI_WSTRB[i]) mem[w_addr[OFF_W +: IDX_W]][8*i +: 8] <= s_axi.S_AXI_WDATA[8*i +: 8];
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      r_last  <= 1'b0;
      r_id    <= '0;
      r_data  <= '0;
      r_resp  <= RESP_OKAY;
    end else if (r_fire_ar || r_fire_r) begin
      r_addr <= r_st.next;
      r_data <= r_st.err ? '0 : mem[rd_a[OFF_W +: IDX_W]];
      r_resp <= r_st.err ? RESP_SLVERR : RESP_OKAY;
      if (r_fire_ar) begin
        r_id    <= s_axi.S_AXI_ARID;
        r_len   <= s_axi.S_AXI_ARLEN;
        r_size  <= s_axi.S_AXI_ARSIZE;
        r_burst <= s_axi.S_AXI_ARBURST;
        r_cnt   <= '0;
        r_last  <= (s_axi.S_AXI_ARLEN == 4'd0);
      end else begin
        r_cnt  <= r_cnt + 4'd1;
        r_last <= (r_cnt + 4'd1 == r_len);
      end
    end
  end

  assign s_axi.S_AXI_BID   = b_id;
  assign s_axi.S_AXI_BRESP = b_resp;
  assign s_axi.S_AXI_RID   = r_id;
  assign s_axi.S_AXI_RDATA = r_data;
  assign s_axi.S_AXI_RRESP = r_resp;
  assign s_axi.S_AXI_RLAST = r_last;
endmodule

// File: tb/tb_axi_ram_slave.sv
// Randomised bench for axi_ram_slave against an array-based reference memory.
// Beat addresses and errors are derived arithmetically from the burst parameters.
module tb_axi_ram_slave;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int ID_W   = 2;
    localparam int DEPTH  = 1024;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_ram_slave_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W)) bus ();

    axi_ram_slave #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .DEPTH_WORDS(DEPTH), .INIT_FILE("")
    ) dut (
        .S_AXI_ACLK(clk),
        .S_AXI_ARESETN(rst_n),
        .s_axi(bus)
    );

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] wr_data [16];
    logic [3:0]  wr_strb [16];
    logic [31:0] rd_log [$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [31:0] model_addr(input logic [31:0] a, input logic [3:0] len,
                                               input logic [2:0] size, input logic [1:0] burst, input int i);
        longint sz, span, lo;
        sz   = longint'(1) << size;
        span = sz * (longint'(len) + 1);
        case (burst)
            2'b00:   return a;
            2'b10: begin
                lo = (longint'(a) / span) * span;
                return 32'(lo + (longint'(a) - lo + i * sz) % span);
            end
            default: return 32'(longint'(a) + i * sz);
        endcase
    endfunction

    function automatic bit model_err(input logic [31:0] a, input logic [3:0] len,
                                     input logic [2:0] size, input logic [1:0] burst);
        int sz;
        sz = 1 << size;
        if ((a >> 2) >= DEPTH) return 1'b1;
        if (sz > DATA_W / 8) return 1'b1;
        if (burst == 2'b11) return 1'b1;
        if (burst == 2'b10) begin
`ifdef AXI_RAM_WRAP_EN
            if (!(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b1;
            if ((a % sz) != 0) return 1'b1;
`else
            return 1'b1;
`endif
        end
        return 1'b0;
    endfunction

    task automatic do_write(input logic [1:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int bad_last);
        int t;
        bit any_err = 1'b0;
        logic [31:0] ba;
        bit e;
        bus.S_AXI_AWID    = id;
        bus.S_AXI_AWADDR  = addr;
        bus.S_AXI_AWLEN   = len;
        bus.S_AXI_AWSIZE  = size;
        bus.S_AXI_AWBURST = burst;
        bus.S_AXI_AWVALID = 1'b1;
        t = 0;
        while (!bus.S_AXI_AWREADY && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) check("aw_timeout", 32'(bus.S_AXI_AWREADY), 1);
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0;
        check("wready_after_aw", 32'(bus.S_AXI_WREADY), 1);
        for (int i = 0; i <= int'(len); i++) begin
            bus.S_AXI_WDATA  = wr_data[i];
            bus.S_AXI_WSTRB  = wr_strb[i];
            bus.S_AXI_WLAST  = (i == int'(len)) ^ (i == bad_last);
            bus.S_AXI_WVALID = 1'b1;
            t = 0;
            while (!bus.S_AXI_WREADY && t < 50) begin @(negedge clk); t++; end
            if (t >= 50) check("w_timeout", 32'(bus.S_AXI_WREADY), 1);
            ba = model_addr(addr, len, size, burst, i);
            e  = model_err(ba, len, size, burst);
            if (!e)
                for (int b = 0; b < 4; b++)
                    if (wr_strb[i][b]) ref_mem[ba >> 2][8*b +: 8] = wr_data[i][8*b +: 8];
            any_err |= e | (bus.S_AXI_WLAST != (i == int'(len)));
            @(negedge clk);
        end
        bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_WLAST  = 1'b0;
        check("bvalid_after_wlast", 32'(bus.S_AXI_BVALID), 1);
        bus.S_AXI_BREADY = 1'b1;
        t = 0;
        while (!bus.S_AXI_BVALID && t < 50) begin @(negedge clk); t++; end
        check("bresp", 32'(bus.S_AXI_BRESP), any_err ? 32'd2 : 32'd0);
        check("bid", 32'(bus.S_AXI_BID), 32'(id));
        @(negedge clk);
        bus.S_AXI_BREADY = 1'b0;
        check("awready_after_b", 32'(bus.S_AXI_AWREADY), 1);
    endtask

    task automatic do_read(input logic [1:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit stall);
        int t, beat, cyc;
        bit rr, held_valid;
        logic [31:0] held, ba, exp;
        bit e;
        bus.S_AXI_ARID    = id;
        bus.S_AXI_ARADDR  = addr;
        bus.S_AXI_ARLEN   = len;
        bus.S_AXI_ARSIZE  = size;
        bus.S_AXI_ARBURST = burst;
        bus.S_AXI_ARVALID = 1'b1;
        t = 0;
        while (!bus.S_AXI_ARREADY && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) check("ar_timeout", 32'(bus.S_AXI_ARREADY), 1);
        @(negedge clk);
        bus.S_AXI_ARVALID = 1'b0;
        rd_log.delete();
        beat = 0;
        cyc = 0;
        held_valid = 1'b0;
        held = '0;
        while (beat <= int'(len) && cyc < 100) begin
            rr = stall ? (cyc % 2 == 0) : 1'b1;
            check("rvalid_held", 32'(bus.S_AXI_RVALID), 1);
            if (held_valid) check("rdata_stable", bus.S_AXI_RDATA, held);
            bus.S_AXI_RREADY = rr;
            held_valid = 1'b0;
            if (bus.S_AXI_RVALID) begin
                if (rr) begin
                    ba  = model_addr(addr, len, size, burst, beat);
                    e   = model_err(ba, len, size, burst);
                    exp = e ? 32'd0 : ref_mem[ba >> 2];
                    check("rdata", bus.S_AXI_RDATA, exp);
                    check("rresp", 32'(bus.S_AXI_RRESP), e ? 32'd2 : 32'd0);
                    check("rlast", 32'(bus.S_AXI_RLAST), 32'(beat == int'(len)));
                    check("rid", 32'(bus.S_AXI_RID), 32'(id));
                    rd_log.push_back(bus.S_AXI_RDATA);
                    beat++;
                end else begin
                    held_valid = 1'b1;
                    held = bus.S_AXI_RDATA;
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus.S_AXI_RREADY = 1'b0;
        if (beat <= int'(len)) check("r_timeout", 32'(beat), 32'(len) + 1);
        check("arready_after_r", 32'(bus.S_AXI_ARREADY), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [31:0] wexp [4];
        int bad;

        bus.S_AXI_AWID = '0;  bus.S_AXI_AWADDR = 32'h10;  bus.S_AXI_AWLEN = '0;
        bus.S_AXI_AWSIZE = 3'd2;  bus.S_AXI_AWBURST = 2'b01;  bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0;  bus.S_AXI_WLAST = 1'b0;  bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARID = '0;  bus.S_AXI_ARADDR = 32'h10;  bus.S_AXI_ARLEN = '0;
        bus.S_AXI_ARSIZE = 3'd2;  bus.S_AXI_ARBURST = 2'b01;  bus.S_AXI_ARVALID = 1'b1;
        bus.S_AXI_RREADY = 1'b0;

        repeat (3) begin
            @(negedge clk);
            check("rst_awready", 32'(bus.S_AXI_AWREADY), 1);
            check("rst_arready", 32'(bus.S_AXI_ARREADY), 1);
            check("rst_wready",  32'(bus.S_AXI_WREADY), 0);
            check("rst_bvalid",  32'(bus.S_AXI_BVALID), 0);
            check("rst_rvalid",  32'(bus.S_AXI_RVALID), 0);
            check("rst_rlast",   32'(bus.S_AXI_RLAST), 0);
            check("rst_bresp",   32'(bus.S_AXI_BRESP), 0);
            check("rst_rresp",   32'(bus.S_AXI_RRESP), 0);
            check("rst_bid",     32'(bus.S_AXI_BID), 0);
            check("rst_rid",     32'(bus.S_AXI_RID), 0);
            check("rst_rdata",   bus.S_AXI_RDATA, 0);
        end
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_ARVALID = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_awready", 32'(bus.S_AXI_AWREADY), 1);
        check("rel_arready", 32'(bus.S_AXI_ARREADY), 1);
        check("rel_wready",  32'(bus.S_AXI_WREADY), 0);
        check("rel_rvalid",  32'(bus.S_AXI_RVALID), 0);

        // Fill the whole array so every later read has a defined expectation.
        for (int b = 0; b < DEPTH / 16; b++) begin
            for (int i = 0; i < 16; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'hF; end
            do_write(2'($urandom_range(0, 3)), 32'(b * 64), 4'd15, 3'd2, 2'b01, -1);
        end

        for (int i = 0; i < 4; i++) begin wr_data[i] = 32'h11111111 * (i + 1); wr_strb[i] = 4'hF; end
        do_write(2'd0, 32'h0, 4'd3, 3'd2, 2'b01, -1);
        do_read(2'd0, 32'h0, 4'd3, 3'd2, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) check("incr_readback", rd_log[i], 32'h11111111 * (i + 1));

        wr_data[0] = 32'h03030303;  wr_strb[0] = 4'hF;
        do_write(2'd1, 32'h4, 4'd0, 3'd2, 2'b01, -1);
        wr_data[0] = 32'hAABBCCDD;  wr_strb[0] = 4'b0101;
        do_write(2'd1, 32'h4, 4'd0, 3'd2, 2'b01, -1);
        do_read(2'd1, 32'h4, 4'd0, 3'd2, 2'b01, 1'b0);
        check("strb_merge", rd_log[0], 32'h03BB03DD);

        do_read(2'd1, 32'h8, 4'd3, 3'd2, 2'b10, 1'b0);
`ifdef AXI_RAM_WRAP_EN
        wexp = '{32'h33333333, 32'h44444444, 32'h11111111, 32'h03BB03DD};
`else
        wexp = '{32'h0, 32'h0, 32'h0, 32'h0};
`endif
        for (int i = 0; i < 4; i++) check("wrap_order", rd_log[i], wexp[i]);

        do_read(2'd2, 32'(DEPTH * 4 - 4), 4'd1, 3'd2, 2'b01, 1'b0);
        check("depth_edge_beat1", rd_log[1], 32'h0);

        for (int i = 0; i < 4; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'hF; end
        do_write(2'd3, 32'h100, 4'd3, 3'd2, 2'b01, 1);

        for (int i = 0; i < 8; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'hF; end
        fork
            do_write(2'd2, 32'h200, 4'd7, 3'd2, 2'b01, -1);
            do_read(2'd1, 32'h300, 4'd7, 3'd2, 2'b01, 1'b1);
        join

        for (int n = 0; n < 60; n++) begin
            size  = 3'($urandom_range(0, 3));
            burst = 2'($urandom_range(0, 3));
            len   = 4'($urandom_range(0, 15));
            a     = 32'($urandom_range(0, DEPTH * 4 + 63));
            if ($urandom_range(0, 7) != 0) a = a & ~((32'd1 << size) - 32'd1);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 16; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'($urandom); end
                bad = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 32'(len))) : -1;
                do_write(2'($urandom_range(0, 3)), a, len, size, burst, bad);
            end else begin
                do_read(2'($urandom_range(0, 3)), a, len, size, burst, 1'($urandom_range(0, 1)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
